vga_pattern_gen: RTL

Parametrised, multi-mode VGA test-pattern generator. It sits between the VGA timing generator (x/y counters plus syncs) and the DAC output pins.
- Animation (breathing border, sweeping XOR pattern) is stepped on frame boundaries derived from vSync, not from free-running slow clocks, so it is tear-free.
- Adds selectable pattern modes, a pause input, synchronous reset, and a fixed 2-cycle pixel pipeline with matched sync delay.

---
 rtl/vga_pattern_pkg.sv | 20 ++
 rtl/vga_anim_ctrl.sv | 117 +++++++++++
 rtl/vga_pattern_gen.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/vga_pattern_pkg.sv
// Shared definitions for the VGA test-pattern generator: pattern modes,
// border direction encoding and default active-area geometry.
package vga_pattern_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    MODE_XOR     = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_t;

  typedef enum logic {
    GROW   = 1'b0,
    SHRINK = 1'b1
  } dir_t;

endpackage

// File: rtl/vga_anim_ctrl.sv
// Frame-locked animation control: vSync falling-edge tick, breathing-border
// FSM, XOR/checker shift counter and the per-frame mode latch.
module vga_anim_ctrl
  import vga_pattern_pkg::*;
#(
  parameter int BORDER_MIN      = 5,
  parameter int BORDER_MAX      = 200,
  parameter int FRAMES_PER_STEP = 1,
  parameter int SHIFT_MAX       = 7,
  parameter int SHIFT_FRAMES    = 60,
  parameter int SHIFT_W         = (SHIFT_MAX > 1) ? $clog2(SHIFT_MAX + 1) : 1
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic               i_vSync,
  input  logic [1:0]         i_mode,
  input  logic               i_pause,
  output logic [9:0]         o_border,
  output logic [SHIFT_W-1:0] o_shift,
  output mode_t              o_mode,
  output logic               o_frame_tick
);

  localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int SCNT_W = (SHIFT_FRAMES > 1) ? $clog2(SHIFT_FRAMES) : 1;
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(FRAMES_PER_STEP - 1);
  localparam logic [SCNT_W-1:0]  SCNT_LAST  = SCNT_W'(SHIFT_FRAMES - 1);
  localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(SHIFT_MAX);
  localparam logic [9:0]         B_MIN      = 10'(BORDER_MIN);
  localparam logic [9:0]         B_MAX      = 10'(BORDER_MAX);

  logic               r_vs_cur, r_vs_prev;
  dir_t               r_dir, w_dir_n;
  logic [9:0]         r_border, w_border_n;
  logic [STEP_W-1:0]  r_step_cnt, w_step_n;
  logic [SHIFT_W-1:0] r_shift, w_shift_n;
  logic [SCNT_W-1:0]  r_shift_cnt, w_scnt_n;
  mode_t              r_mode, w_mode_n;
  logic               w_tick;

  assign w_tick = r_vs_prev & ~r_vs_cur;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_vs_cur    <= 1'b1;
      r_vs_prev   <= 1'b1;
      r_dir       <= GROW;
      r_border    <= B_MIN;
      r_step_cnt  <= '0;
      r_shift     <= '0;
      r_shift_cnt <= '0;
      r_mode      <= MODE_XOR;
    end else begin
      r_vs_cur    <= i_vSync;
      r_vs_prev   <= r_vs_cur;
      r_dir       <= w_dir_n;
      r_border    <= w_border_n;
      r_step_cnt  <= w_step_n;
      r_shift     <= w_shift_n;
      r_shift_cnt <= w_scnt_n;
      r_mode      <= w_mode_n;
    end
  end

  // The mode follows every tick; everything else freezes while paused.
  always_comb begin
    w_dir_n    = r_dir;
    w_border_n = r_border;
    w_step_n   = r_step_cnt;
    w_shift_n  = r_shift;
    w_scnt_n   = r_shift_cnt;
    w_mode_n   = r_mode;
    if (w_tick) begin
      w_mode_n = mode_t'(i_mode);
      if (!i_pause) begin
        if (r_step_cnt == STEP_LAST) begin
          w_step_n = '0;
          case (r_dir)
            GROW: begin
              if (r_border == B_MAX) begin
                w_dir_n    = SHRINK;
                w_border_n = B_MAX - 10'd1;
              end else begin
                w_border_n = r_border + 10'd1;
              end
            end
            SHRINK: begin
              if (r_border == B_MIN) begin
                w_dir_n    = GROW;
                w_border_n = B_MIN + 10'd1;
              end else begin
                w_border_n = r_border - 10'd1;
              end
            end
            default: ;
          endcase
        end else begin
          w_step_n = r_step_cnt + STEP_W'(1);
        end
        if (r_shift_cnt == SCNT_LAST) begin
          w_scnt_n  = '0;
          w_shift_n = (r_shift == SHIFT_LAST) ? '0 : r_shift + SHIFT_W'(1);
        end else begin
          w_scnt_n = r_shift_cnt + SCNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    o_border     = r_border;
    o_shift      = r_shift;
    o_mode       = r_mode;
    o_frame_tick = w_tick;
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Multi-mode VGA test-pattern generator: two-stage pixel pipeline (blank and
// pattern, then output select) with syncs delayed by the same two cycles.
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int COLOR_BITS      = 3,
  parameter int H_ACTIVE        = H_ACTIVE_DEF,
  parameter int V_ACTIVE        = V_ACTIVE_DEF,
  parameter int BORDER_MIN      = 5,
  parameter int BORDER_MAX      = 200,
  parameter int FRAMES_PER_STEP = 1,
  parameter int SHIFT_MAX       = 7,
  parameter int SHIFT_FRAMES    = 60
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_hSync,
  input  logic                  i_vSync,
  input  logic [9:0]            i_x_pos,
  input  logic [9:0]            i_y_pos,
  input  logic [1:0]            i_mode,
  input  logic                  i_pause,
  output logic [COLOR_BITS-1:0] o_red,
  output logic [COLOR_BITS-1:0] o_green,
  output logic [COLOR_BITS-1:0] o_blue,
  output logic                  o_hSync,
  output logic                  o_vSync,
  output logic                  o_frame_tick
);

  localparam int SHIFT_W = (SHIFT_MAX > 1) ? $clog2(SHIFT_MAX + 1) : 1;
  localparam logic [10:0]           H11  = 11'(H_ACTIVE);
  localparam logic [10:0]           V11  = 11'(V_ACTIVE);
  localparam logic [COLOR_BITS-1:0] ALL1 = '1;

  logic [9:0]            w_border;
  logic [SHIFT_W-1:0]    w_shift;
  mode_t                 w_mode;
  logic [10:0]           w_x11, w_y11, w_b11;
  logic                  w_blank;
  logic [9:0]            w_xy;
  logic [2:0]            w_bar;
  logic [3:0]            w_xor_idx, w_chk_idx;
  logic [COLOR_BITS-1:0] w_pat_r, w_pat_g, w_pat_b;
  logic                  r_blank;
  logic [COLOR_BITS-1:0] r_pat_r, r_pat_g, r_pat_b;
  logic [COLOR_BITS-1:0] r_red, r_green, r_blue;
  logic                  r_hs1, r_hs2, r_vs1, r_vs2;

  vga_anim_ctrl #(
    .BORDER_MIN      (BORDER_MIN),
    .BORDER_MAX      (BORDER_MAX),
    .FRAMES_PER_STEP (FRAMES_PER_STEP),
    .SHIFT_MAX       (SHIFT_MAX),
    .SHIFT_FRAMES    (SHIFT_FRAMES),
    .SHIFT_W         (SHIFT_W)
  ) u_anim (
    .i_CLK        (i_CLK),
    .i_RST        (i_RST),
    .i_vSync      (i_vSync),
    .i_mode       (i_mode),
    .i_pause      (i_pause),
    .o_border     (w_border),
    .o_shift      (w_shift),
    .o_mode       (w_mode),
    .o_frame_tick (o_frame_tick)
  );

  // 11-bit arithmetic keeps H_ACTIVE-border and friends from wrapping.
  assign w_x11   = {1'b0, i_x_pos};
  assign w_y11   = {1'b0, i_y_pos};
  assign w_b11   = {1'b0, w_border};
  assign w_blank = (w_x11 >= H11) | (w_y11 >= V11) | (w_x11 < w_b11) |
                   (w_x11 >= H11 - w_b11) | (w_y11 < w_b11) |
                   (w_y11 >= V11 - w_b11);

  assign w_xy      = i_x_pos ^ i_y_pos;
  assign w_bar     = i_x_pos[9:7];
  assign w_xor_idx = 4'(w_shift);
  assign w_chk_idx = 4'(w_shift) + 4'd2;

  always_comb begin
    w_pat_r = '0;
    w_pat_g = '0;
    w_pat_b = '0;
    case (w_mode)
      MODE_XOR: w_pat_g = w_xy[w_xor_idx] ? '0 : ALL1;
      MODE_BARS: begin
        w_pat_r = {COLOR_BITS{w_bar[2]}};
        w_pat_g = {COLOR_BITS{w_bar[1]}};
        w_pat_b = {COLOR_BITS{w_bar[0]}};
      end
      MODE_CHECKER: begin
        if (i_x_pos[w_chk_idx] ^ i_y_pos[w_chk_idx]) begin
          w_pat_r = ALL1;
          w_pat_g = ALL1;
          w_pat_b = ALL1;
        end
      end
      MODE_SOLID: begin
        w_pat_r = ALL1;
        w_pat_g = ALL1;
        w_pat_b = ALL1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_blank <= 1'b1;
      r_pat_r <= '0;
      r_pat_g <= '0;
      r_pat_b <= '0;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
      r_hs1   <= 1'b1;
      r_hs2   <= 1'b1;
      r_vs1   <= 1'b1;
      r_vs2   <= 1'b1;
    end else begin
      r_blank <= w_blank;
      r_pat_r <= w_pat_r;
      r_pat_g <= w_pat_g;
      r_pat_b <= w_pat_b;
      r_red   <= r_blank ? '0 : r_pat_r;
      r_green <= r_blank ? '0 : r_pat_g;
      r_blue  <= r_blank ? '0 : r_pat_b;
      r_hs1   <= i_hSync;
      r_hs2   <= r_hs1;
      r_vs1   <= i_vSync;
      r_vs2   <= r_vs1;
    end
  end

  assign o_red   = r_red;
  assign o_green = r_green;
  assign o_blue  = r_blue;
  assign o_hSync = r_hs2;
  assign o_vSync = r_vs2;

endmodule
